// File: rtl/tpg_mode_sequencer_if.sv
// Mode handshake between the sequencer and the pattern mode mux, plus the
// generator enable that is gated by that handshake.
interface tpg_mode_sequencer_if #(
   parameter int MODE_W = 3
);
   logic [MODE_W-1:0] mode_o;      // current or requested mode index
   logic              mode_req_o;  // mode change request, level
   logic              mode_ack_i;  // mux acknowledges mode_o
   logic              enable_o;    // generator enable

   // Sequencer side
   modport master (
      output mode_o,
      output mode_req_o,
      output enable_o,
      input  mode_ack_i
   );

   // Mode mux / generator side
   modport slave (
      input  mode_o,
      input  mode_req_o,
      input  enable_o,
      output mode_ack_i
   );
endinterface

// File: rtl/tpg_mode_sequencer.sv
// Steps the test pattern generator through the enabled pattern modes, holding
// each for a programmable number of frames and switching only on end-of-frame.
// Every switch is confirmed by the mux (req/ack) before the generator restarts.
module tpg_mode_sequencer #(
   parameter int NUM_MODES      = 5,
   parameter int MODE_W         = 3,
   parameter int FRAMES_DEFAULT = 60,
   parameter int DW             = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_i,        // async, active low
   input  logic                        cfg_valid_i,
   input  logic [DW-1:0]               cfg_i,
   input  logic                        start_i,
   input  logic                        stop_i,
   input  logic                        eof_i,
   tpg_mode_sequencer_if.master        mode_if,
   output logic [15:0]                 frame_cnt_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        cfg_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWITCH = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   // Registered state and outputs
   state_t                 r_state;
   logic [MODE_W-1:0]      r_mode;
   logic                   r_mode_req;
   logic                   r_enable;
   logic [15:0]            r_frame_cnt;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_cfg_err;
   logic                   r_stop_pend;
   // Shadow configuration
   logic [NUM_MODES-1:0]   r_mask;
   logic [15:0]            r_frames;
   logic                   r_loop;

   // Next-state values
   state_t                 w_state_nxt;
   logic [MODE_W-1:0]      w_mode_nxt;
   logic                   w_mode_req_nxt;
   logic                   w_enable_nxt;
   logic [15:0]            w_frame_cnt_nxt;
   logic                   w_done_nxt;
   logic                   w_cfg_err_nxt;
   logic                   w_stop_pend_nxt;
   logic [NUM_MODES-1:0]   w_mask_nxt;
   logic [15:0]            w_frames_nxt;
   logic                   w_loop_nxt;

   // Decode helpers
   logic [NUM_MODES-1:0]   w_cfg_mask;
   logic [15:0]            w_cfg_frames;
   logic [NUM_MODES-1:0]   w_mask_eff;
   logic [MODE_W-1:0]      w_first_mode;
   logic [MODE_W-1:0]      w_next_mode;
   logic                   w_wrapped;
   logic                   w_found;
   int                     w_pos;
   logic                   w_stop_eff;
   logic                   w_last_frame;
   logic [15:0]            w_frame_inc;

   // Reserved configuration bits are intentionally ignored
   logic                   w_unused;
   assign w_unused = ^cfg_i;

   // Decode the incoming config word; a start in the same cycle sees it
   always_comb begin
      w_cfg_mask   = cfg_i[NUM_MODES-1:0];
      w_cfg_frames = (cfg_i[23:8] == 16'd0) ? 16'd1 : cfg_i[23:8];
      w_mask_eff   = cfg_valid_i ? w_cfg_mask : r_mask;
      w_first_mode = '0;
      for (int i = NUM_MODES - 1; i >= 0; i--) begin
         if (1'(w_mask_eff >> i)) w_first_mode = MODE_W'(i);
      end
   end

   // Circular search for the next enabled mode after the current one
   always_comb begin
      w_next_mode = r_mode;
      w_wrapped   = 1'b0;
      w_found     = 1'b0;
      w_pos       = 0;
      for (int i = 1; i <= NUM_MODES; i++) begin
         w_pos = int'(r_mode) + i;
         if (!w_found && 1'(r_mask >> (w_pos % NUM_MODES))) begin
            w_found     = 1'b1;
            w_next_mode = MODE_W'(w_pos % NUM_MODES);
            w_wrapped   = (w_pos >= NUM_MODES);
         end
      end
   end

   assign w_stop_eff   = r_stop_pend | stop_i;
   assign w_last_frame = (r_frame_cnt == r_frames - 16'd1);
   assign w_frame_inc  = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;

   // Next-state and output decode for IDLE / SWITCH / RUN
   always_comb begin
      // NOTE: every target gets its hold value first so no branch can infer a latch.
      w_state_nxt     = r_state;
      w_mode_nxt      = r_mode;
      w_mode_req_nxt  = r_mode_req;
      w_enable_nxt    = r_enable;
      w_frame_cnt_nxt = r_frame_cnt;
      w_done_nxt      = 1'b0;
      w_cfg_err_nxt   = 1'b0;
      w_stop_pend_nxt = r_stop_pend;
      w_mask_nxt      = r_mask;
      w_frames_nxt    = r_frames;
      w_loop_nxt      = r_loop;

      unique case (r_state)
         ST_IDLE: begin
            w_stop_pend_nxt = 1'b0;
            if (cfg_valid_i) begin
               w_mask_nxt   = w_cfg_mask;
               w_frames_nxt = w_cfg_frames;
               w_loop_nxt   = cfg_i[24];
            end
            if (start_i) begin
               if (w_mask_eff != '0) begin
                  w_mode_nxt      = w_first_mode;
                  w_frame_cnt_nxt = 16'd0;
                  w_mode_req_nxt  = 1'b1;
                  w_enable_nxt    = 1'b0;
                  w_state_nxt     = ST_SWITCH;
               end else begin
                  w_cfg_err_nxt = 1'b1;
               end
            end
         end

         ST_SWITCH: begin
            if (cfg_valid_i) w_cfg_err_nxt = 1'b1;
            if (stop_i) w_stop_pend_nxt = 1'b1;
            if (mode_if.mode_ack_i) begin
               w_mode_req_nxt = 1'b0;
               if (w_stop_eff) begin
                  w_stop_pend_nxt = 1'b0;
                  w_enable_nxt    = 1'b0;
                  w_state_nxt     = ST_IDLE;
               end else begin
                  w_enable_nxt = 1'b1;
                  w_state_nxt  = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (cfg_valid_i) w_cfg_err_nxt = 1'b1;
            if (stop_i) w_stop_pend_nxt = 1'b1;
            if (eof_i) begin
               w_frame_cnt_nxt = w_frame_inc;
               if (w_last_frame || w_stop_eff) begin
                  if (w_stop_eff) begin
                     w_stop_pend_nxt = 1'b0;
                     w_enable_nxt    = 1'b0;
                     w_state_nxt     = ST_IDLE;
                  end else if (w_wrapped && !r_loop) begin
                     w_enable_nxt = 1'b0;
                     w_done_nxt   = 1'b1;
                     w_state_nxt  = ST_IDLE;
                  end else begin
                     w_mode_nxt      = w_next_mode;
                     w_frame_cnt_nxt = 16'd0;
                     w_mode_req_nxt  = 1'b1;
                     w_enable_nxt    = 1'b0;
                     w_state_nxt     = ST_SWITCH;
                  end
               end
            end
         end

         default: begin
            w_mode_req_nxt = 1'b0;
            w_enable_nxt   = 1'b0;
            w_state_nxt    = ST_IDLE;
         end
      endcase
   end

   // State, output and shadow config registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= ST_IDLE;
         r_mode      <= '0;
         r_mode_req  <= 1'b0;
         r_enable    <= 1'b0;
         r_frame_cnt <= 16'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_stop_pend <= 1'b0;
         r_mask      <= '1;
         r_frames    <= 16'(FRAMES_DEFAULT);
         r_loop      <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         r_state     <= w_state_nxt;
         r_mode      <= w_mode_nxt;
         r_mode_req  <= w_mode_req_nxt;
         r_enable    <= w_enable_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= w_done_nxt;
         r_cfg_err   <= w_cfg_err_nxt;
         r_stop_pend <= w_stop_pend_nxt;
         r_mask      <= w_mask_nxt;
         r_frames    <= w_frames_nxt;
         r_loop      <= w_loop_nxt;
      end
   end

   assign mode_if.mode_o     = r_mode;
   assign mode_if.mode_req_o = r_mode_req;
   assign mode_if.enable_o   = r_enable;
   assign frame_cnt_o        = r_frame_cnt;
   assign busy_o             = r_busy;
   assign done_o             = r_done;
   assign cfg_err_o          = r_cfg_err;

endmodule

// File: tb/tb_tpg_mode_sequencer.sv
// Directed bench for tpg_mode_sequencer: default sweep, one-shot sequence,
// graceful stop, rejected cfg/start, single-mode looping and async reset.
module tb_tpg_mode_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        cfg_valid_i = 1'b0;
   logic [31:0] cfg_i = 32'h0;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        eof_i = 1'b0;
   logic [15:0] frame_cnt_o;
   logic        busy_o;
   logic        done_o;
   logic        cfg_err_o;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int done_base;
   int lowcnt;

   tpg_mode_sequencer_if #(.MODE_W(3)) mode_if ();

   tpg_mode_sequencer #(
      .NUM_MODES(5), .MODE_W(3), .FRAMES_DEFAULT(60), .DW(32)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_i       (cfg_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .eof_i       (eof_i),
      .mode_if     (mode_if),
      .frame_cnt_o (frame_cnt_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .cfg_err_o   (cfg_err_o)
   );

   // 100 MHz clock
   always #5 clk_i = ~clk_i;

   // Count done pulses independently of the directed checks
   always @(posedge clk_i) if (done_o) done_cnt <= done_cnt + 1;

   // Hard time limit so the run always ends
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clocks; inputs change and outputs are sampled 1 ns after the edge
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic pulse_eof();
      eof_i = 1'b1;
      cyc(1);
      eof_i = 1'b0;
   endtask

   task automatic start_seq();
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
   endtask

   task automatic load_cfg(input logic [31:0] word);
      cfg_i       = word;
      cfg_valid_i = 1'b1;
      cyc(1);
      cfg_valid_i = 1'b0;
   endtask

   // Wait (bounded) for a request, then acknowledge it for one cycle
   task automatic ack_now();
      int k = 0;
      while (!mode_if.mode_req_o && k < 50) begin
         cyc(1);
         k++;
      end
      if (k == 50) check("req_timeout", 32'(mode_if.mode_req_o), 32'd1);
      mode_if.mode_ack_i = 1'b1;
      cyc(1);
      mode_if.mode_ack_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      cfg_valid_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; eof_i = 1'b0;
      mode_if.mode_ack_i = 1'b0;
      cyc(2);
      rst_i = 1'b1;
      cyc(1);
   endtask

   initial begin
      mode_if.mode_ack_i = 1'b0;
      #1;
      cyc(2);

      // ---- 1: reset state, default sweep over all modes ----
      check("rst_mode",   32'(mode_if.mode_o),     32'd0);
      check("rst_req",    32'(mode_if.mode_req_o), 32'd0);
      check("rst_en",     32'(mode_if.enable_o),   32'd0);
      check("rst_busy",   32'(busy_o),             32'd0);
      check("rst_cnt",    32'(frame_cnt_o),        32'd0);
      rst_i = 1'b1;
      cyc(1);
      start_seq();
      for (int m = 0; m < 5; m++) begin
         check("t1_mode", 32'(mode_if.mode_o),     32'(m));
         check("t1_req",  32'(mode_if.mode_req_o), 32'd1);
         check("t1_cnt0", 32'(frame_cnt_o),        32'd0);
         lowcnt = 0;
         while (!mode_if.enable_o && lowcnt < 20) begin
            if (lowcnt == 3) mode_if.mode_ack_i = 1'b1;
            lowcnt++;
            cyc(1);
            mode_if.mode_ack_i = 1'b0;
         end
         check("t1_en_low_cycles", 32'(lowcnt), 32'd4);
         check("t1_req_drop", 32'(mode_if.mode_req_o), 32'd0);
         repeat (59) pulse_eof();
         check("t1_cnt59",  32'(frame_cnt_o),    32'd59);
         check("t1_en_run", 32'(mode_if.enable_o), 32'd1);
         check("t1_hold",   32'(mode_if.mode_o), 32'(m));
         pulse_eof();
      end
      check("t1_wrap_mode", 32'(mode_if.mode_o),     32'd0);
      check("t1_wrap_req",  32'(mode_if.mode_req_o), 32'd1);

      // ---- 2: mask 10100, 2 frames, no loop; cfg and start together ----
      do_reset();
      done_base = done_cnt;
      cfg_i = 32'h0000_0214;
      cfg_valid_i = 1'b1;
      start_i = 1'b1;
      cyc(1);
      cfg_valid_i = 1'b0;
      start_i = 1'b0;
      check("t2_first_mode", 32'(mode_if.mode_o),     32'd2);
      check("t2_first_req",  32'(mode_if.mode_req_o), 32'd1);
      ack_now();
      check("t2_en", 32'(mode_if.enable_o), 32'd1);
      pulse_eof();
      check("t2_cnt1", 32'(frame_cnt_o),    32'd1);
      check("t2_hold", 32'(mode_if.mode_o), 32'd2);
      pulse_eof();
      check("t2_second_mode", 32'(mode_if.mode_o),     32'd4);
      check("t2_second_req",  32'(mode_if.mode_req_o), 32'd1);
      check("t2_cnt_clr",     32'(frame_cnt_o),        32'd0);
      ack_now();
      pulse_eof();
      pulse_eof();
      check("t2_done",     32'(done_o),              32'd1);
      check("t2_busy",     32'(busy_o),              32'd0);
      check("t2_en_off",   32'(mode_if.enable_o),    32'd0);
      check("t2_req_off",  32'(mode_if.mode_req_o),  32'd0);
      check("t2_mode_kept", 32'(mode_if.mode_o),     32'd4);
      cyc(2);
      check("t2_done_once", 32'(done_cnt - done_base), 32'd1);

      // ---- 3: graceful stop in mode 1 at frame 5 of 10 ----
      load_cfg(32'h0100_0A02);
      start_seq();
      check("t3_mode", 32'(mode_if.mode_o), 32'd1);
      ack_now();
      repeat (5) pulse_eof();
      check("t3_cnt5", 32'(frame_cnt_o), 32'd5);
      done_base = done_cnt;
      stop_i = 1'b1;
      cyc(1);
      stop_i = 1'b0;
      check("t3_still_busy", 32'(busy_o),           32'd1);
      check("t3_still_en",   32'(mode_if.enable_o), 32'd1);
      pulse_eof();
      check("t3_idle",  32'(busy_o),              32'd0);
      check("t3_en",    32'(mode_if.enable_o),    32'd0);
      check("t3_req",   32'(mode_if.mode_req_o),  32'd0);
      check("t3_mode1", 32'(mode_if.mode_o),      32'd1);
      cyc(2);
      check("t3_no_done", 32'(done_cnt - done_base), 32'd0);
      check("t3_no_req",  32'(mode_if.mode_req_o),   32'd0);

      // ---- 4: cfg during RUN is rejected; start with empty mask rejected ----
      start_seq();
      ack_now();
      load_cfg(32'h0000_0000);
      check("t4_err_run",  32'(cfg_err_o),        32'd1);
      check("t4_busy_run", 32'(busy_o),           32'd1);
      check("t4_en_run",   32'(mode_if.enable_o), 32'd1);
      cyc(1);
      check("t4_err_pulse", 32'(cfg_err_o), 32'd0);
      repeat (9) pulse_eof();
      check("t4_frames_kept", 32'(frame_cnt_o),         32'd9);
      check("t4_no_switch",   32'(mode_if.mode_req_o),  32'd0);
      pulse_eof();
      check("t4_mask_kept", 32'(mode_if.mode_o),     32'd1);
      check("t4_switch",    32'(mode_if.mode_req_o), 32'd1);
      stop_i = 1'b1;
      cyc(1);
      stop_i = 1'b0;
      ack_now();
      check("t4_stop_in_switch", 32'(busy_o),           32'd0);
      check("t4_stop_en",        32'(mode_if.enable_o), 32'd0);
      load_cfg(32'h0000_0000);
      check("t4_idle_cfg_ok", 32'(cfg_err_o), 32'd0);
      start_seq();
      check("t4_err_start",  32'(cfg_err_o),           32'd1);
      check("t4_start_busy", 32'(busy_o),              32'd0);
      check("t4_start_req",  32'(mode_if.mode_req_o),  32'd0);

      // ---- frames_per_mode = 0 behaves as 1 ----
      load_cfg(32'h0000_0003);
      start_seq();
      ack_now();
      pulse_eof();
      check("f0_next_mode", 32'(mode_if.mode_o),     32'd1);
      check("f0_next_req",  32'(mode_if.mode_req_o), 32'd1);
      ack_now();
      pulse_eof();
      check("f0_done", 32'(done_o), 32'd1);
      check("f0_idle", 32'(busy_o), 32'd0);

      // ---- 5: single mode 3, loop, 1 frame; eof in SWITCH ignored ----
      load_cfg(32'h0100_0108);
      start_seq();
      check("t5_mode", 32'(mode_if.mode_o), 32'd3);
      pulse_eof();
      check("t5_eof_ignored", 32'(frame_cnt_o),        32'd0);
      check("t5_req_held",    32'(mode_if.mode_req_o), 32'd1);
      check("t5_en_low",      32'(mode_if.enable_o),   32'd0);
      ack_now();
      for (int r = 0; r < 2; r++) begin
         pulse_eof();
         check("t5_reswitch_mode", 32'(mode_if.mode_o),     32'd3);
         check("t5_reswitch_req",  32'(mode_if.mode_req_o), 32'd1);
         check("t5_reswitch_cnt",  32'(frame_cnt_o),        32'd0);
         ack_now();
         check("t5_run_en", 32'(mode_if.enable_o), 32'd1);
      end

      // ---- 6: async reset while a request is pending ----
      pulse_eof();
      check("t6_pre_req", 32'(mode_if.mode_req_o), 32'd1);
      #2 rst_i = 1'b0;
      #1;
      check("t6_mode", 32'(mode_if.mode_o),     32'd0);
      check("t6_req",  32'(mode_if.mode_req_o), 32'd0);
      check("t6_en",   32'(mode_if.enable_o),   32'd0);
      check("t6_busy", 32'(busy_o),             32'd0);
      check("t6_cnt",  32'(frame_cnt_o),        32'd0);
      check("t6_done", 32'(done_o),             32'd0);
      check("t6_err",  32'(cfg_err_o),          32'd0);
      #1 rst_i = 1'b1;
      cyc(1);
      start_seq();
      check("t6_default_mode", 32'(mode_if.mode_o),     32'd0);
      check("t6_default_req",  32'(mode_if.mode_req_o), 32'd1);
      ack_now();
      repeat (59) pulse_eof();
      check("t6_default_cnt",  32'(frame_cnt_o),        32'd59);
      check("t6_default_hold", 32'(mode_if.mode_o),     32'd0);
      pulse_eof();
      check("t6_default_next", 32'(mode_if.mode_o),     32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tpg_mode_sequencer.md
Name: tpg_mode_sequencer

Overview:
- Controller that automatically steps the test pattern generator through a programmable list of pattern modes.
- Each mode is held for a programmable number of frames. Mode changes happen only at frame boundaries, signalled by the generator's end-of-video pulse.
- A req/ack handshake with the mode mux confirms each change before output is re-enabled.
- Sits between the Avalon-MM register block and the mode mux / generator enable inputs.

Parameters:
- NUM_MODES, 5: number of pattern modes (0=stndrt, 1=offset, 2=grad, 3=onecolor, 4=image); legal range 2..8.
- MODE_W, 3: width of the mode index.
- FRAMES_DEFAULT, 60: frames-per-mode value loaded at reset.
- DW, 32: configuration word width.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  one-cycle strobe that loads cfg_i
- cfg_i  in  DW  configuration word:
  - [NUM_MODES-1:0] mode_mask
  - [23:8] frames_per_mode
  - [24] loop
- start_i  in  1  begin sequence (pulse)
- stop_i  in  1  graceful stop request (pulse)
- eof_i  in  1  end-of-frame pulse from the generator
- mode_ack_i  in  1  mux acknowledges mode_o
- mode_o  out  MODE_W  current or requested mode index
- mode_req_o  out  1  mode change request, level
- enable_o  out  1  generator enable
- frame_cnt_o  out  16  frames completed in the current mode
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse at normal sequence completion
- cfg_err_o  out  1  one-cycle pulse on a rejected cfg or start

Behaviour:
- Reset (async, rst_i=0): all outputs 0.
  - Shadow config resets to mask = all ones, frames = FRAMES_DEFAULT, loop = 1.
  - State goes to IDLE; stop_pend is cleared.
- Config: cfg_valid_i is accepted only in IDLE, latched on the same edge.
  - In any other state the word is ignored and cfg_err_o pulses on the next cycle.
  - frames_per_mode = 0 is treated as 1.
- Next-mode function: circular search from (cur+1) mod NUM_MODES for the first set mask bit.
  - "wrapped" is asserted when the search passes index NUM_MODES-1.
  - A single-bit mask returns the same mode with wrapped = 1.
- States:
  - IDLE: start_i with mask != 0 loads mode_o = lowest set mask bit, clears frame_cnt_o, and enters SWITCH on the next cycle. start_i with mask == 0 stays in IDLE and pulses cfg_err_o. stop_i is ignored. start_i and cfg_valid_i in the same cycle: the new cfg is latched first and start uses it.
  - SWITCH: mode_req_o = 1 and enable_o = 0; eof_i is ignored. On mode_ack_i, mode_req_o drops the following cycle. If stop_pend is set, go to IDLE (enable_o stays 0, stop_pend cleared). Otherwise go to RUN with enable_o = 1 from the cycle after the ack. An ack in the first SWITCH cycle is legal (minimum switch latency 2 cycles).
  - RUN: enable_o = 1. Each eof_i increments frame_cnt_o (16-bit, saturating).
    - Boundary condition: eof_i with frame_cnt_o == frames-1, or eof_i with stop_pend set.
    - If stop_pend: go to IDLE, enable_o = 0 the next cycle, no done_o pulse.
    - Else if wrapped and loop == 0: go to IDLE, enable_o = 0, done_o pulses.
    - Otherwise: mode_o = next mode, frame_cnt_o = 0, go to SWITCH. mode_req_o is asserted in the cycle after the eof.
- stop_i:
  - In RUN or SWITCH it sets stop_pend.
  - stop_i coinciding with a boundary eof_i counts as stopping at that eof.
  - start_i outside IDLE is ignored.
- busy_o = (state != IDLE), registered together with the state.
- mode_o holds its last value in IDLE.
- Reset mid-SWITCH or mid-RUN returns immediately to reset values; no handshake completion is required.

Test Plan:
1. Reset, then start with default cfg (all modes, 60 frames), ack each request after 3 cycles.
   - Modes go 0→1→2→3→4→0.
   - Each mode gets exactly 60 eof pulses with enable_o = 1.
   - enable_o is low for exactly 4 cycles per switch.
2. cfg mask = 0b10100, frames = 2, loop = 0; start; 4 eofs with immediate acks.
   - Sequence is mode 2 then mode 4, then IDLE.
   - done_o pulses once; enable_o = 0.
3. stop_i in RUN mode 1 at frame_cnt = 5 of 10.
   - Stays in mode 1 until the next eof, then IDLE with enable_o = 0.
   - No done_o, no mode_req_o.
4. cfg_valid_i during RUN; start_i with mask = 0 in IDLE.
   - cfg_err_o pulses in both cases.
   - Shadow config is unchanged; state is unchanged.
5. Single-mode mask = 0b01000, loop = 1, frames = 1.
   - Every eof triggers a SWITCH back to mode 3 with a fresh req/ack.
   - eof_i injected during SWITCH is ignored (frame_cnt_o stays 0).
6. rst_i asserted while mode_req_o = 1.
   - All outputs are 0 asynchronously.
   - After release, cfg equals the default and start works normally.
